// File: rtl/noc_egress_buffer.sv
// Egress buffer between the NoC and the egress checker: a DEPTH-entry FIFO with
// no bypass path, a packet-framing checker on accepted flits, and delivery counters.
module noc_egress_buffer #(
  parameter int DEPTH            = 4,
  parameter int INGRESS_BITS     = 64,
  parameter int PAYLOAD_BITS     = 64,
  parameter int CYCLE_COUNT_BITS = 64
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_head,
  input  logic                        in_tail,
  input  logic [INGRESS_BITS-1:0]     in_ingress_id,
  input  logic [PAYLOAD_BITS-1:0]     in_payload,
  output logic                        noc_valid,
  output logic                        flit_in_head,
  output logic                        flit_in_tail,
  output logic [INGRESS_BITS-1:0]     flit_in_ingress_id,
  output logic [PAYLOAD_BITS-1:0]     flit_in_payload,
  input  logic                        egressunit_ready,
  output logic [CYCLE_COUNT_BITS-1:0] cycle_count,
  output logic [31:0]                 flit_count,
  output logic [31:0]                 packet_count,
  output logic                        proto_error,
  output logic [1:0]                  error_code,
  output logic                        dbg_pkt_state
);

  // DEPTH must be a power of two (>= 2) so the pointers wrap by plain overflow.
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 2 + INGRESS_BITS + PAYLOAD_BITS;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } pkt_state_e;

  logic [ENTRY_W-1:0]          mem_q [DEPTH];
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic                        accept_en_q;
  logic                        full, empty, enq, deq;
  logic [ENTRY_W-1:0]          in_entry, head_entry;

  pkt_state_e                  state_q;
  logic [INGRESS_BITS-1:0]     pkt_id_q;
  logic                        proto_error_q;
  logic [1:0]                  error_code_q;

  logic [CYCLE_COUNT_BITS-1:0] cycle_count_q;
  logic [31:0]                 flit_count_q;
  logic [31:0]                 packet_count_q;

  // Handshake: a transfer happens on a rising edge where valid && ready; valid
  // never waits on ready, and the presented fields hold while valid && !ready.
  // in_ready stays low until the first edge after reset release.
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = accept_en_q && !full;
  assign noc_valid = !empty;
  assign enq       = in_valid && in_ready;
  assign deq       = noc_valid && egressunit_ready;

  assign in_entry   = {in_head, in_tail, in_ingress_id, in_payload};
  assign head_entry = empty ? '0 : mem_q[rd_ptr_q];
  assign {flit_in_head, flit_in_tail, flit_in_ingress_id, flit_in_payload} = head_entry;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      accept_en_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      accept_en_q <= 1'b1;
    end
  end

  // Storage needs no reset: unoccupied entries are never presented.
  always_ff @(posedge clock) begin
    if (enq) mem_q[wr_ptr_q] <= in_entry;
  end

  // Framing checker; only the first error is recorded.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      pkt_id_q      <= '0;
      proto_error_q <= 1'b0;
      error_code_q  <= 2'd0;
    end else if (enq) begin
      case (state_q)
        ST_IDLE: begin
          if (in_head) begin
            state_q  <= in_tail ? ST_IDLE : ST_IN_PKT;
            pkt_id_q <= in_ingress_id;
          end else if (!proto_error_q) begin
            proto_error_q <= 1'b1;
            error_code_q  <= 2'd2;
          end
        end
        ST_IN_PKT: begin
          if (in_head) begin
            state_q  <= in_tail ? ST_IDLE : ST_IN_PKT;
            pkt_id_q <= in_ingress_id;
            if (!proto_error_q) begin
              proto_error_q <= 1'b1;
              error_code_q  <= 2'd1;
            end
          end else begin
            if (in_tail) state_q <= ST_IDLE;
            if ((in_ingress_id != pkt_id_q) && !proto_error_q) begin
              proto_error_q <= 1'b1;
              error_code_q  <= 2'd3;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_count_q  <= '0;
      flit_count_q   <= '0;
      packet_count_q <= '0;
    end else begin
      cycle_count_q <= cycle_count_q + CYCLE_COUNT_BITS'(1);
      if (deq) begin
        flit_count_q <= flit_count_q + 32'd1;
        if (flit_in_tail) packet_count_q <= packet_count_q + 32'd1;
      end
    end
  end

  assign cycle_count   = cycle_count_q;
  assign flit_count    = flit_count_q;
  assign packet_count  = packet_count_q;
  assign proto_error   = proto_error_q;
  assign error_code    = error_code_q;
  assign dbg_pkt_state = state_q;

endmodule

// File: tb/tb_noc_egress_buffer.sv
// Directed bench for noc_egress_buffer: hand-computed checks plus an in-order
// scoreboard on every delivered flit.
module tb_noc_egress_buffer;

  localparam int W = 130;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_head, in_tail, egressunit_ready;
  logic [63:0] in_ingress_id, in_payload;
  logic        in_ready, noc_valid, flit_in_head, flit_in_tail;
  logic [63:0] flit_in_ingress_id, flit_in_payload, cycle_count;
  logic [31:0] flit_count, packet_count;
  logic        proto_error, dbg_pkt_state;
  logic [1:0]  error_code;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  noc_egress_buffer dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_head(in_head), .in_tail(in_tail),
    .in_ingress_id(in_ingress_id), .in_payload(in_payload),
    .noc_valid(noc_valid), .flit_in_head(flit_in_head), .flit_in_tail(flit_in_tail),
    .flit_in_ingress_id(flit_in_ingress_id), .flit_in_payload(flit_in_payload),
    .egressunit_ready(egressunit_ready), .cycle_count(cycle_count),
    .flit_count(flit_count), .packet_count(packet_count),
    .proto_error(proto_error), .error_code(error_code),
    .dbg_pkt_state(dbg_pkt_state)
  );

  // Clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: sampled on the falling edge, when inputs and outputs are settled.
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      if (noc_valid && egressunit_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL sb_underflow observed=flit id %0h required=no flit", flit_in_ingress_id);
          end
        end else begin
          chk("sb_order", {flit_in_head, flit_in_tail, flit_in_ingress_id, flit_in_payload},
              exp_q.pop_front());
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back({in_head, in_tail, in_ingress_id, in_payload});
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic h, input logic t, input logic [63:0] id, input logic [63:0] pl);
    logic ok;
    ok = 1'b0;
    step();
    in_valid = 1'b1; in_head = h; in_tail = t; in_ingress_id = id; in_payload = pl;
    for (int k = 0; k < 64; k++) begin
      @(negedge clock);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("send_accept", W'(ok), W'(1));
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    for (int k = 0; k < 64; k++) begin
      @(negedge clock);
      if (!noc_valid) break;
    end
    chk("drain_done", W'(noc_valid), W'(0));
  endtask

  initial begin : stim
    logic held;
    logic ok;
    int   stalls;
    reset = 1'b0; in_valid = 1'b0; in_head = 1'b0; in_tail = 1'b0;
    in_ingress_id = '0; in_payload = '0; egressunit_ready = 1'b0;

    // Reset values
    #12;
    chk("rst_in_ready", W'(in_ready), W'(0));
    chk("rst_noc_valid", W'(noc_valid), W'(0));
    chk("rst_cycle", W'(cycle_count), W'(0));
    chk("rst_flits", W'(flit_count), W'(0));
    chk("rst_pkts", W'(packet_count), W'(0));
    chk("rst_perr", W'({proto_error, error_code}), W'(0));
    chk("rst_payload", W'(flit_in_payload), W'(0));
    chk("rst_state", W'(dbg_pkt_state), W'(0));
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rel_in_ready", W'(in_ready), W'(1));
    chk("rel_cycle", W'(cycle_count), W'(1));

    // Single head&tail flit, no bypass
    step();
    egressunit_ready = 1'b1;
    in_valid = 1'b1; in_head = 1'b1; in_tail = 1'b1; in_ingress_id = 64'd5; in_payload = 64'hAB;
    @(negedge clock);
    chk("nobypass_valid", W'(noc_valid), W'(0));
    step();
    in_valid = 1'b0;
    @(negedge clock);
    chk("single_valid", W'(noc_valid), W'(1));
    chk("single_id", W'(flit_in_ingress_id), W'(5));
    chk("single_payload", W'(flit_in_payload), W'(64'hAB));
    chk("single_framing", W'({flit_in_head, flit_in_tail}), W'(2'b11));
    step();
    @(negedge clock);
    chk("single_drained", W'(noc_valid), W'(0));
    chk("single_flits", W'(flit_count), W'(1));
    chk("single_pkts", W'(packet_count), W'(1));

    // Fill to full with the checker stalled
    step();
    egressunit_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b1, 1'b1, 64'd10 + 64'(i), 64'h100 + 64'(i));
    @(negedge clock);
    chk("full_in_ready", W'(in_ready), W'(0));
    chk("full_noc_valid", W'(noc_valid), W'(1));
    step();
    in_valid = 1'b1; in_head = 1'b1; in_tail = 1'b1; in_ingress_id = 64'd14; in_payload = 64'h104;
    held = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (in_ready) held = 1'b0;
    end
    chk("fifth_held", W'(held), W'(1));
    chk("stall_stable", W'(flit_in_payload), W'(64'h100));
    step();
    egressunit_ready = 1'b1;
    @(negedge clock);
    chk("full_deq_no_enq", W'(in_ready), W'(0));
    ok = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("in_ready_returns", W'(ok), W'(1));
    step();
    in_valid = 1'b0;
    wait_empty();
    chk("fill_flits", W'(flit_count), W'(6));
    chk("fill_pkts", W'(packet_count), W'(6));

    // Ingress id change inside a packet
    send(1'b1, 1'b0, 64'd2, 64'h200);
    send(1'b0, 1'b0, 64'd2, 64'h201);
    send(1'b0, 1'b1, 64'd3, 64'h202);
    @(negedge clock);
    chk("idchg_error", W'({proto_error, error_code}), W'(3'b111));
    wait_empty();
    chk("idchg_flits", W'(flit_count), W'(9));
    chk("idchg_pkts", W'(packet_count), W'(7));

    // Reset mid-operation with an open packet and 3 buffered flits
    step();
    egressunit_ready = 1'b0;
    send(1'b1, 1'b0, 64'd7, 64'h700);
    send(1'b0, 1'b0, 64'd7, 64'h701);
    send(1'b0, 1'b0, 64'd7, 64'h702);
    @(negedge clock);
    chk("open_pkt_state", W'(dbg_pkt_state), W'(1));
    #1;
    reset = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_noc_valid", W'(noc_valid), W'(0));
    chk("mid_rst_in_ready", W'(in_ready), W'(0));
    chk("mid_rst_counts", W'({flit_count, packet_count}), W'(0));
    chk("mid_rst_cycle", W'(cycle_count), W'(0));
    chk("mid_rst_perr", W'({proto_error, error_code}), W'(0));
    chk("mid_rst_payload", W'(flit_in_payload), W'(0));
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("post_rst_cycle", W'(cycle_count), W'(1));
    chk("post_rst_empty", W'(noc_valid), W'(0));

    // Body in IDLE, then a repeated head: first code sticks
    step();
    egressunit_ready = 1'b1;
    send(1'b0, 1'b0, 64'd1, 64'h300);
    @(negedge clock);
    chk("body_idle_code", W'({proto_error, error_code}), W'(3'b110));
    send(1'b1, 1'b0, 64'd4, 64'h301);
    @(negedge clock);
    chk("head_opens_pkt", W'(dbg_pkt_state), W'(1));
    send(1'b1, 1'b1, 64'd4, 64'h302);
    @(negedge clock);
    chk("sticky_code", W'({proto_error, error_code}), W'(3'b110));
    chk("headtail_closes", W'(dbg_pkt_state), W'(0));
    wait_empty();
    chk("sticky_flits", W'(flit_count), W'(3));
    chk("sticky_pkts", W'(packet_count), W'(1));

    // Streaming at occupancy 2 across many pointer wraps
    step();
    egressunit_ready = 1'b0;
    send(1'b1, 1'b1, 64'd50, 64'h500);
    send(1'b1, 1'b1, 64'd51, 64'h501);
    step();
    egressunit_ready = 1'b1;
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_head = 1'b1; in_tail = 1'b1;
      in_ingress_id = 64'd200 + 64'(i);
      in_payload = 64'hC0DE_0000_0000_0000 | 64'(i);
      @(negedge clock);
      if (!(in_ready && noc_valid)) stalls++;
      step();
    end
    in_valid = 1'b0;
    chk("stream_stalls", W'(stalls), W'(0));
    wait_empty();
    chk("stream_flits", W'(flit_count), W'(105));
    chk("stream_pkts", W'(packet_count), W'(103));
    chk("sb_leftover", W'(exp_q.size()), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
